// File: rtl/regfile_2r1w_dbg.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_dbg
//
// This is the integer register file that answers the id stage's register
// reads. It has two combinational read ports, one synchronous writeback
// write port and a 4-phase handshaked debug port. The debug port can read
// or write any GPR.
//
// x0 always reads as zero. Writes to x0 from either source are dropped.
// A read port whose address matches the writeback address in the same
// cycle returns the writeback data (bypass). Debug writes are not bypassed:
// they become visible through storage on the cycle after the write edge.
// When a pipeline write and a debug write compete, the pipeline write wins.
// The debug write then waits in IDLE and retries every cycle.
//
// Optional build macro: REGFILE_PARITY_EN
//   When defined, every entry also stores an even-parity bit computed at
//   write time. This adds the par_inject_i input and the sticky
//   parity_err_o output.
//
// Ports:
//   clk_i          clock; all state changes on the rising edge
//   rst_n_i        asynchronous active-low reset
//   reg1_raddr_i   read port 1 address
//   reg1_re_i      read port 1 enable
//   reg1_rdata_o   read port 1 data (combinational)
//   reg2_raddr_i   read port 2 address
//   reg2_re_i      read port 2 enable
//   reg2_rdata_o   read port 2 data (combinational)
//   reg_we_i       writeback write enable
//   reg_waddr_i    writeback address
//   reg_wdata_i    writeback data
//   dbg_req_i      debug request (4-phase)
//   dbg_we_i       debug write (1) / read (0), sampled with the request
//   dbg_addr_i     debug register address
//   dbg_wdata_i    debug write data
//   dbg_ack_o      debug acknowledge (registered)
//   dbg_rdata_o    debug read data (registered, valid while dbg_ack_o=1)
//   par_inject_i   [REGFILE_PARITY_EN] invert the stored parity of a pipeline write
//   parity_err_o   [REGFILE_PARITY_EN] sticky parity error flag (registered)
// ---------------------------------------------------------------------------
module regfile_2r1w_dbg #(
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,

    input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic                   reg1_re_i,
    output logic [RDATA_WIDTH-1:0] reg1_rdata_o,

    input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
    input  logic                   reg2_re_i,
    output logic [RDATA_WIDTH-1:0] reg2_rdata_o,

    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,

    input  logic                   dbg_req_i,
    input  logic                   dbg_we_i,
    input  logic [RADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [RDATA_WIDTH-1:0] dbg_wdata_i,
    output logic                   dbg_ack_o,
    output logic [RDATA_WIDTH-1:0] dbg_rdata_o
`ifdef REGFILE_PARITY_EN
    ,
    input  logic                   par_inject_i,
    output logic                   parity_err_o
`endif
);

    localparam int NREGS = 2 ** RADDR_WIDTH;
    localparam logic [RADDR_WIDTH-1:0] ZERO_ADDR = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } dbg_state_t;

    logic [RDATA_WIDTH-1:0] mem [NREGS];
    dbg_state_t             dbg_state;

    // Pipeline write qualified against x0.
    logic pipe_wr;
    // Debug access taken at this edge (only from IDLE).
    logic dbg_fire;
    logic dbg_wr_fire;
    logic dbg_rd_fire;

    // Same-cycle address match against the writeback port.
    logic rd1_hit;
    logic rd2_hit;
    logic dbg_hit;

    logic [RDATA_WIDTH-1:0] dbg_read_val;

    assign pipe_wr = reg_we_i && (reg_waddr_i != ZERO_ADDR);

    // A debug write is held off for as long as the pipeline is writing. A
    // debug read can always proceed, because it does not touch storage.
    assign dbg_fire    = (dbg_state == IDLE) && dbg_req_i && !(dbg_we_i && reg_we_i);
    assign dbg_wr_fire = dbg_fire && dbg_we_i;
    assign dbg_rd_fire = dbg_fire && !dbg_we_i;

    assign rd1_hit = reg_we_i && (reg_waddr_i == reg1_raddr_i);
    assign rd2_hit = reg_we_i && (reg_waddr_i == reg2_raddr_i);
    assign dbg_hit = reg_we_i && (reg_waddr_i == dbg_addr_i);

    // -----------------------------------------------------------------------
    // Combinational read ports
    // The x0 check comes before the bypass, so a writeback aimed at x0
    // can never leak through.
    // -----------------------------------------------------------------------
    always_comb begin
        reg1_rdata_o = '0;
        if (reg1_re_i && (reg1_raddr_i != ZERO_ADDR)) begin
            reg1_rdata_o = rd1_hit ? reg_wdata_i : mem[reg1_raddr_i];
        end
    end

    always_comb begin
        reg2_rdata_o = '0;
        if (reg2_re_i && (reg2_raddr_i != ZERO_ADDR)) begin
            reg2_rdata_o = rd2_hit ? reg_wdata_i : mem[reg2_raddr_i];
        end
    end

    // The debug read uses the same bypass rule as the read ports.
    always_comb begin
        dbg_read_val = '0;
        if (dbg_addr_i != ZERO_ADDR) begin
            dbg_read_val = dbg_hit ? reg_wdata_i : mem[dbg_addr_i];
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par [NREGS];
    logic rd1_chk;
    logic rd2_chk;
    logic dbg_chk;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic par_bad(input logic [RDATA_WIDTH-1:0] data, input logic p);
        return (^data) != p;
    endfunction

    // A bypassed read returns the writeback data rather than storage, so it
    // does not check storage.
    assign rd1_chk = reg1_re_i && (reg1_raddr_i != ZERO_ADDR) && !rd1_hit
                     && par_bad(mem[reg1_raddr_i], par[reg1_raddr_i]);
    assign rd2_chk = reg2_re_i && (reg2_raddr_i != ZERO_ADDR) && !rd2_hit
                     && par_bad(mem[reg2_raddr_i], par[reg2_raddr_i]);
    assign dbg_chk = dbg_rd_fire && (dbg_addr_i != ZERO_ADDR) && !dbg_hit
                     && par_bad(mem[dbg_addr_i], par[dbg_addr_i]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            parity_err_o <= 1'b0;
        end else if (rd1_chk || rd2_chk || dbg_chk) begin
            parity_err_o <= 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Storage update
    // The pipeline write is checked first. The debug write never fires while
    // reg_we_i is high, but the priority order still states the intent.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
`ifdef REGFILE_PARITY_EN
                par[i] <= 1'b0;
`endif
            end
        end else if (pipe_wr) begin
            mem[reg_waddr_i] <= reg_wdata_i;
`ifdef REGFILE_PARITY_EN
            par[reg_waddr_i] <= (^reg_wdata_i) ^ par_inject_i;
`endif
        end else if (dbg_wr_fire && (dbg_addr_i != ZERO_ADDR)) begin
            mem[dbg_addr_i] <= dbg_wdata_i;
`ifdef REGFILE_PARITY_EN
            par[dbg_addr_i] <= ^dbg_wdata_i;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Debug handshake FSM
    // The access takes place on the edge that leaves IDLE. While in ACK,
    // dbg_ack_o and dbg_rdata_o stay fixed until the requester drops
    // dbg_req_i, so later changes to the address or data are ignored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbg_state   <= IDLE;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            case (dbg_state)
                IDLE: begin
                    if (dbg_fire) begin
                        dbg_state   <= ACK;
                        dbg_ack_o   <= 1'b1;
                        dbg_rdata_o <= dbg_we_i ? '0 : dbg_read_val;
                    end
                end
                ACK: begin
                    if (!dbg_req_i) begin
                        dbg_state <= IDLE;
                        dbg_ack_o <= 1'b0;
                    end
                end
                default: begin
                    dbg_state <= IDLE;
                    dbg_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_dbg.sv
module tb_regfile_2r1w_dbg;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  reg1_raddr_i;
    logic        reg1_re_i;
    logic [31:0] reg1_rdata_o;
    logic [4:0]  reg2_raddr_i;
    logic        reg2_re_i;
    logic [31:0] reg2_rdata_o;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
`ifdef REGFILE_PARITY_EN
    logic        par_inject_i;
    logic        parity_err_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    regfile_2r1w_dbg #(
        .RADDR_WIDTH(5),
        .RDATA_WIDTH(32)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .reg1_raddr_i (reg1_raddr_i),
        .reg1_re_i    (reg1_re_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_raddr_i (reg2_raddr_i),
        .reg2_re_i    (reg2_re_i),
        .reg2_rdata_o (reg2_rdata_o),
        .reg_we_i     (reg_we_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_rdata_o  (dbg_rdata_o)
`ifdef REGFILE_PARITY_EN
        ,
        .par_inject_i (par_inject_i),
        .parity_err_o (parity_err_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step 1 time unit away from it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        reg1_raddr_i = '0;
        reg1_re_i    = 1'b0;
        reg2_raddr_i = '0;
        reg2_re_i    = 1'b0;
        reg_we_i     = 1'b0;
        reg_waddr_i  = '0;
        reg_wdata_i  = '0;
        dbg_req_i    = 1'b0;
        dbg_we_i     = 1'b0;
        dbg_addr_i   = '0;
        dbg_wdata_i  = '0;
`ifdef REGFILE_PARITY_EN
        par_inject_i = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        check("rst_dbg_rdata", dbg_rdata_o, 32'd0);
`ifdef REGFILE_PARITY_EN
        check("rst_par_err", {31'd0, parity_err_o}, 32'd0);
`endif
        rst_n_i = 1'b1;
        step();

        reg1_re_i = 1'b1;
        reg2_re_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            reg1_raddr_i = 5'(i);
            reg2_raddr_i = 5'(31 - i + 1);
            #1;
            check($sformatf("rst_p1_x%0d", i), reg1_rdata_o, 32'd0);
            check($sformatf("rst_p2_x%0d", 32 - i), reg2_rdata_o, 32'd0);
        end

        // Pipeline write x5 with a same-cycle bypass on port 1. Port 2 is disabled.
        reg_we_i     = 1'b1;
        reg_waddr_i  = 5'd5;
        reg_wdata_i  = 32'hDEADBEEF;
        reg1_raddr_i = 5'd5;
        reg2_raddr_i = 5'd5;
        reg2_re_i    = 1'b0;
        #1;
        check("bypass_p1_x5", reg1_rdata_o, 32'hDEADBEEF);
        check("re0_p2_x5", reg2_rdata_o, 32'd0);
        step();
        reg_we_i = 1'b0;
        #1;
        check("stored_p1_x5", reg1_rdata_o, 32'hDEADBEEF);
        check("re0_p2_x5_after", reg2_rdata_o, 32'd0);
        reg2_re_i = 1'b1;
        #1;
        check("stored_p2_x5", reg2_rdata_o, 32'hDEADBEEF);

        // A write to x0 is dropped and is not bypassed.
        reg_we_i     = 1'b1;
        reg_waddr_i  = 5'd0;
        reg_wdata_i  = 32'h12345678;
        reg1_raddr_i = 5'd0;
        reg2_raddr_i = 5'd0;
        #1;
        check("x0_p1_same", reg1_rdata_o, 32'd0);
        check("x0_p2_same", reg2_rdata_o, 32'd0);
        step();
        reg_we_i = 1'b0;
        #1;
        check("x0_p1_after", reg1_rdata_o, 32'd0);
        check("x0_p2_after", reg2_rdata_o, 32'd0);

        // A debug write to x7 stalls behind 3 cycles of pipeline writes to x10.
        reg_we_i    = 1'b1;
        reg_waddr_i = 5'd10;
        reg_wdata_i = 32'h00001111;
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'b1;
        dbg_addr_i  = 5'd7;
        dbg_wdata_i = 32'hA5A5A5A5;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall_ack_c%0d", c), {31'd0, dbg_ack_o}, 32'd0);
        end
        reg_we_i     = 1'b0;
        reg1_raddr_i = 5'd7;
        reg2_raddr_i = 5'd10;
        #1;
        check("stall_x7_unwritten", reg1_rdata_o, 32'd0);
        step();
        check("dbgw_ack", {31'd0, dbg_ack_o}, 32'd1);
        check("dbgw_rdata", dbg_rdata_o, 32'd0);
        check("dbgw_x7_stored", reg1_rdata_o, 32'hA5A5A5A5);
        check("pipe_x10_stored", reg2_rdata_o, 32'h00001111);
        dbg_req_i = 1'b0;
        step();
        check("dbgw_ack_fall", {31'd0, dbg_ack_o}, 32'd0);

        // A debug read of x7 ignores an address change made after the access edge.
        dbg_req_i  = 1'b1;
        dbg_we_i   = 1'b0;
        dbg_addr_i = 5'd7;
        #1;
        check("dbgr_ack_pre", {31'd0, dbg_ack_o}, 32'd0);
        step();
        check("dbgr_ack", {31'd0, dbg_ack_o}, 32'd1);
        check("dbgr_rdata_x7", dbg_rdata_o, 32'hA5A5A5A5);
        dbg_addr_i = 5'd10;
        step();
        check("dbgr_hold_ack", {31'd0, dbg_ack_o}, 32'd1);
        check("dbgr_hold_rdata", dbg_rdata_o, 32'hA5A5A5A5);
        dbg_req_i = 1'b0;
        step();
        check("dbgr_ack_fall", {31'd0, dbg_ack_o}, 32'd0);

        // A debug write to x0 is acknowledged but dropped.
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'b1;
        dbg_addr_i  = 5'd0;
        dbg_wdata_i = 32'hFFFFFFFF;
        step();
        check("dbgw_x0_ack", {31'd0, dbg_ack_o}, 32'd1);
        dbg_req_i    = 1'b0;
        reg1_raddr_i = 5'd0;
        #1;
        check("dbgw_x0_dropped", reg1_rdata_o, 32'd0);
        step();

`ifdef REGFILE_PARITY_EN
        // A clean write to x4 must not flag an error.
        reg_we_i     = 1'b1;
        reg_waddr_i  = 5'd4;
        reg_wdata_i  = 32'h1;
        par_inject_i = 1'b0;
        step();
        reg_we_i     = 1'b0;
        reg1_raddr_i = 5'd4;
        step();
        check("par_x4_clean", {31'd0, parity_err_o}, 32'd0);
        // Write x3 with injected parity. Its read is flagged one edge later.
        reg_we_i     = 1'b1;
        reg_waddr_i  = 5'd3;
        reg_wdata_i  = 32'h1;
        par_inject_i = 1'b1;
        reg1_raddr_i = 5'd3;
        step();
        check("par_bypass_no_flag", {31'd0, parity_err_o}, 32'd0);
        reg_we_i     = 1'b0;
        par_inject_i = 1'b0;
        #1;
        check("par_x3_before_edge", {31'd0, parity_err_o}, 32'd0);
        step();
        check("par_x3_flag", {31'd0, parity_err_o}, 32'd1);
        reg1_raddr_i = 5'd4;
        step();
        check("par_x3_sticky", {31'd0, parity_err_o}, 32'd1);
`endif

        // A debug read of x9 coincides with a pipeline write of x9, so it takes the bypass.
        reg_we_i     = 1'b1;
        reg_waddr_i  = 5'd9;
        reg_wdata_i  = 32'h00000055;
        dbg_req_i    = 1'b1;
        dbg_we_i     = 1'b0;
        dbg_addr_i   = 5'd9;
        step();
        check("dbgr_bypass_ack", {31'd0, dbg_ack_o}, 32'd1);
        check("dbgr_bypass_x9", dbg_rdata_o, 32'h00000055);
        reg_we_i     = 1'b0;
        reg1_raddr_i = 5'd9;
        reg2_raddr_i = 5'd5;
        #1;
        check("x9_stored", reg1_rdata_o, 32'h00000055);

        // Reset in the middle of the transaction, with dbg_req_i held high.
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_ack", {31'd0, dbg_ack_o}, 32'd0);
        check("midrst_dbg_rdata", dbg_rdata_o, 32'd0);
        check("midrst_x9", reg1_rdata_o, 32'd0);
        check("midrst_x5", reg2_rdata_o, 32'd0);
`ifdef REGFILE_PARITY_EN
        check("midrst_par_err", {31'd0, parity_err_o}, 32'd0);
`endif
        #1;
        rst_n_i = 1'b1;
        step();
        check("postrst_new_ack", {31'd0, dbg_ack_o}, 32'd1);
        check("postrst_x9_rdata", dbg_rdata_o, 32'd0);
        dbg_req_i = 1'b0;
        step();
        check("postrst_ack_fall", {31'd0, dbg_ack_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
